// File: rtl/shift_pkg.sv
// ============================================================================
// shift_pkg : shared types and constants for the SRC shift unit
// Revision  : 1.0
// ============================================================================
`default_nettype none

package shift_pkg;

  localparam int SHIFT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_SHR  = 2'd0,
    OP_SHRA = 2'd1,
    OP_SHL  = 2'd2,
    OP_SHC  = 2'd3
  } shift_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shift_state_t;

endpackage

`default_nettype wire

// File: rtl/shift_unit_if.sv
// ============================================================================
// shift_unit_if : control handshake between sequencer, count register and CPU
// Revision      : 1.0
// ============================================================================
`default_nettype none

interface shift_unit_if;

  logic       ld_a;
  logic       start;
  logic [1:0] op;
  logic       n;
  logic       c_out;
  logic       decr;
  logic       busy;
  logic       done;

  modport master (
    output ld_a, start, op, n, c_out,
    input  decr, busy, done
  );

  modport slave (
    input  ld_a, start, op, n, c_out,
    output decr, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/shift_step.sv
// ============================================================================
// shift_step : combinational one-bit shift/rotate of a w-bit value
// Option     : SHIFT_ROTATE_EN enables rotate-left for OP_SHC
// Revision   : 1.0
// ============================================================================
`default_nettype none

module shift_step
  import shift_pkg::*;
#(
  parameter int w = SHIFT_W_DEFAULT
) (
  input  logic [w-1:0] a,
  input  shift_op_t    op,
  output logic [w-1:0] y
);

  always_comb begin
    y = {1'b0, a[w-1:1]};
    case (op)
      OP_SHR:  y = {1'b0, a[w-1:1]};
      OP_SHRA: y = {a[w-1], a[w-1:1]};
      OP_SHL:  y = {a[w-2:0], 1'b0};
`ifdef SHIFT_ROTATE_EN
      OP_SHC:  y = {a[w-2:0], a[w-1]};
`else
      // Without rotate support SHC degrades to a logical right shift
      OP_SHC:  y = {1'b0, a[w-1:1]};
`endif
      default: y = {1'b0, a[w-1:1]};
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/shift_unit.sv
// ============================================================================
// shift_unit : operand register, shift sequencer and bus driver for SRC shifts
// Option     : SHIFT_ROTATE_EN (see shift_step)
// Revision   : 1.0
// ============================================================================
`default_nettype none

module shift_unit
  import shift_pkg::*;
#(
  parameter int w = SHIFT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  inout  wire  [w-1:0] bus,
  shift_unit_if.slave  ctl,
  output logic [1:0]   tb_state
);

  shift_state_t r_state;
  shift_state_t w_next;
  shift_op_t    r_op;
  logic [w-1:0] r_a;
  logic [w-1:0] w_step;
  logic         w_decr;
  logic         w_busy;
  logic         w_done;

  shift_step #(.w(w)) u_step (
    .a  (r_a),
    .op (r_op),
    .y  (w_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_op    <= OP_SHR;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE) begin
        // A same-cycle load and start runs the sequence on the new operand
        if (ctl.ld_a)  r_a  <= bus;
        if (ctl.start) r_op <= shift_op_t'(ctl.op);
      end else if (r_state == ST_SHIFT && !ctl.n) begin
        r_a <= w_step;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_decr = 1'b0;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ctl.start) w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_busy = 1'b1;
        if (ctl.n) w_next = ST_DONE;
        else       w_decr = 1'b1;
      end
      ST_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign ctl.decr = w_decr;
  assign ctl.busy = w_busy;
  assign ctl.done = w_done;
  assign tb_state = r_state;

  assign bus = (ctl.c_out && r_state == ST_IDLE) ? r_a : {w{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_shift_unit.sv
// ============================================================================
// tb_shift_unit : randomized self-checking bench for shift_unit with a count
//                 register model and an arithmetic reference for each op
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_shift_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Pulled-up bus: an undriven bus reads as all ones
  tri1 [W-1:0] bus;
  logic         drv_en;
  logic [W-1:0] drv_val;
  assign bus = drv_en ? drv_val : {W{1'bz}};

  logic [1:0] tb_state;
  logic [5:0] cnt;
  logic       cnt_ld;
  logic [5:0] cnt_val;

  shift_unit_if ctl ();

  // Shift-count register paired with the unit
  always @(posedge clk) begin
    if (rst)            cnt <= '0;
    else if (cnt_ld)    cnt <= cnt_val;
    else if (ctl.decr)  cnt <= cnt - 6'd1;
  end
  assign ctl.n = (cnt == 6'd0);

  shift_unit #(.w(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ctl      (ctl),
    .tb_state (tb_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input int k, input logic [1:0] op);
    logic [31:0] r;
    case (op)
      2'd0: r = a >> k;
      2'd1: r = $signed(a) >>> k;
      2'd2: r = a << k;
      default: begin
`ifdef SHIFT_ROTATE_EN
        r = (k == 0) ? a : ((a << k) | (a >> (32 - k)));
`else
        r = a >> k;
`endif
      end
    endcase
    return r;
  endfunction

  task automatic clear_inputs();
    drv_en      = 1'b0;
    drv_val     = '0;
    ctl.ld_a    = 1'b0;
    ctl.start   = 1'b0;
    ctl.c_out   = 1'b0;
    cnt_ld      = 1'b0;
  endtask

  task automatic load_and_start(input logic [31:0] a, input int k, input logic [1:0] op);
    @(negedge clk);
    drv_en   = 1'b1;
    drv_val  = a;
    ctl.ld_a = 1'b1;
    cnt_ld   = 1'b1;
    cnt_val  = 6'(k);
    @(negedge clk);
    clear_inputs();
    ctl.start = 1'b1;
    ctl.op    = op;
    @(negedge clk);
    ctl.start = 1'b0;
  endtask

  task automatic run_seq(input logic [31:0] a, input int k, input logic [1:0] op, input bit noise);
    int decr_cnt = 0;
    int done_at  = -1;
    int busy_bad = 0;
    logic [31:0] exp;
    exp = model(a, k, op);
    load_and_start(a, k, op);
    for (int j = 0; j < k + 8 && done_at < 0; j++) begin
      if (ctl.decr) decr_cnt++;
      if (ctl.done) done_at = j;
      if (!ctl.busy) busy_bad++;
      clear_inputs();
      if (noise) begin
        case ($urandom_range(0, 3))
          0: begin
            ctl.c_out = 1'b1;
            #1;
            chk("bus_hiz_busy", bus, '1);
          end
          1: begin
            ctl.start = 1'b1;
            ctl.op    = 2'($urandom);
          end
          2: begin
            drv_en   = 1'b1;
            drv_val  = $urandom;
            ctl.ld_a = 1'b1;
          end
          default: ;
        endcase
      end
      @(negedge clk);
    end
    clear_inputs();
    chk("decr_cycles", 32'(decr_cnt), 32'(k));
    chk("done_cycle", 32'(done_at), 32'(k + 1));
    chk("busy_during_seq", 32'(busy_bad), 32'd0);
    chk("done_one_cycle", {31'd0, ctl.done}, 32'd0);
    chk("idle_after_done", {30'd0, tb_state}, 32'd0);
    ctl.c_out = 1'b1;
    #1;
    chk("result", bus, exp);
    ctl.c_out = 1'b0;
  endtask

  task automatic reset_mid_seq();
    int done_seen = 0;
    load_and_start(32'hDEAD_BEEF, 5, 2'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_state", {30'd0, tb_state}, 32'd0);
    chk("rst_busy", {31'd0, ctl.busy}, 32'd0);
    chk("rst_decr", {31'd0, ctl.decr}, 32'd0);
    for (int j = 0; j < 4; j++) begin
      if (ctl.done) done_seen++;
      @(negedge clk);
    end
    chk("rst_no_done", 32'(done_seen), 32'd0);
    ctl.c_out = 1'b1;
    #1;
    chk("rst_a_zero", bus, 32'd0);
    ctl.c_out = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    ctl.op  = 2'd0;
    cnt_val = '0;
    clear_inputs();
    repeat (3) @(negedge clk);
    chk("reset_state", {30'd0, tb_state}, 32'd0);
    chk("reset_busy", {31'd0, ctl.busy}, 32'd0);
    chk("reset_done", {31'd0, ctl.done}, 32'd0);
    chk("reset_decr", {31'd0, ctl.decr}, 32'd0);
    chk("reset_bus_hiz", bus, '1);
    ctl.c_out = 1'b1;
    #1;
    chk("reset_a", bus, 32'd0);
    ctl.c_out = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run_seq(32'h8000_00F0, 4,  2'd0, 1'b0);
    run_seq(32'h8000_00F0, 4,  2'd1, 1'b0);
    run_seq(32'h0000_0001, 31, 2'd2, 1'b0);
    run_seq(32'h8000_0001, 1,  2'd3, 1'b0);
    run_seq(32'h1234_5678, 0,  2'd2, 1'b0);
    run_seq(32'hFFFF_0000, 31, 2'd1, 1'b1);
    reset_mid_seq();
    for (int i = 0; i < 24; i++)
      run_seq($urandom, int'($urandom_range(0, 31)), 2'($urandom), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
